// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between NREQ requesters: valid/ready grant, issue, latency wait, tagged response.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of the default round-robin.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_mode,
  input  logic [NREQ*CW-1:0]      req_cmd,
  input  logic [2*NREQ-1:0]       req_inp_valid,
  input  logic [NREQ*DW-1:0]      req_opa,
  input  logic [NREQ*DW-1:0]      req_opb,
  input  logic [NREQ-1:0]         req_cin,
  output logic                    alu_ce,
  output logic [1:0]              alu_inp_valid,
  output logic                    alu_mode,
  output logic [CW-1:0]           alu_cmd,
  output logic [DW-1:0]           alu_opa,
  output logic [DW-1:0]           alu_opb,
  output logic                    alu_cin,
  input  logic [2*DW-1:0]         alu_res,
  input  logic [5:0]              alu_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*DW-1:0]         rsp_res,
  output logic [5:0]              rsp_flags
);

  localparam int IW      = $clog2(NREQ);
  localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] CMD_MUL_A = CW'(9);
  localparam logic [CW-1:0] CMD_MUL_B = CW'(10);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             grant;

  logic [IW-1:0]    id_q, id_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cmd_q, cmd_d;
  logic [1:0]       inp_valid_q, inp_valid_d;
  logic [DW-1:0]    opa_q, opa_d;
  logic [DW-1:0]    opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [2*DW-1:0]  res_q, res_d;
  logic [5:0]       flags_q, flags_d;

  logic             is_mul;
  logic             lat_done;

  assign grant    = (state_q == IDLE) && win_found;
  assign is_mul   = mode_q && ((cmd_q == CMD_MUL_A) || (cmd_q == CMD_MUL_B));
  assign lat_done = (lat_cnt_q == CNT_W'(1));

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        win_idx   = IW'(k);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  // Scan offsets from farthest to nearest so the requester just after rr_ptr wins.
  always_comb begin
    int idx;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        win_idx   = IW'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = win_idx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr_q <= IW'(NREQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    alu_ce        = 1'b0;
    alu_inp_valid = 2'b00;
    alu_mode      = 1'b0;
    alu_cmd       = '0;
    alu_opa       = '0;
    alu_opb       = '0;
    alu_cin       = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && !RST) begin
          req_ready[win_idx] = 1'b1;
        end
      end
      ISSUE, WAIT: begin
        alu_ce        = 1'b1;
        alu_inp_valid = inp_valid_q;
        alu_mode      = mode_q;
        alu_cmd       = cmd_q;
        alu_opa       = opa_q;
        alu_opb       = opb_q;
        alu_cin       = cin_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;

  // Command fields are latched at grant; the ALU result is latched on the last latency edge.
  always_comb begin
    id_d        = id_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    inp_valid_d = inp_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cin_d       = cin_q;
    lat_cnt_d   = lat_cnt_q;
    res_d       = res_q;
    flags_d     = flags_q;
    if (grant) begin
      id_d        = win_idx;
      mode_d      = req_mode[win_idx];
      cmd_d       = req_cmd[int'(win_idx)*CW +: CW];
      inp_valid_d = req_inp_valid[int'(win_idx)*2 +: 2];
      opa_d       = req_opa[int'(win_idx)*DW +: DW];
      opb_d       = req_opb[int'(win_idx)*DW +: DW];
      cin_d       = req_cin[win_idx];
    end
    case (state_q)
      ISSUE: lat_cnt_d = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
      WAIT: begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
        if (lat_done) begin
          res_d   = alu_res;
          flags_d = alu_flags;
        end
      end
      default: lat_cnt_d = lat_cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      id_q        <= '0;
      mode_q      <= 1'b0;
      cmd_q       <= '0;
      inp_valid_q <= 2'b00;
      opa_q       <= '0;
      opb_q       <= '0;
      cin_q       <= 1'b0;
      lat_cnt_q   <= '0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      id_q        <= id_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      inp_valid_q <= inp_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cin_q       <= cin_d;
      lat_cnt_q   <= lat_cnt_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: idle reset state, single command, arbitration order,
// multiply latency, response back-pressure and asynchronous reset mid-command.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_mode;
  logic [NREQ*CW-1:0] req_cmd;
  logic [2*NREQ-1:0] req_inp_valid;
  logic [NREQ*DW-1:0] req_opa;
  logic [NREQ*DW-1:0] req_opb;
  logic [NREQ-1:0]   req_cin;
  logic              alu_ce;
  logic [1:0]        alu_inp_valid;
  logic              alu_mode;
  logic [CW-1:0]     alu_cmd;
  logic [DW-1:0]     alu_opa;
  logic [DW-1:0]     alu_opb;
  logic              alu_cin;
  logic [2*DW-1:0]   alu_res;
  logic [5:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*DW-1:0]   rsp_res;
  logic [5:0]        rsp_flags;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_order [5];

  always #5 CLK = ~CLK;

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .LAT(1), .MUL_LAT(2)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid), .req_opa(req_opa),
    .req_opb(req_opb), .req_cin(req_cin),
    .alu_ce(alu_ce), .alu_inp_valid(alu_inp_valid), .alu_mode(alu_mode),
    .alu_cmd(alu_cmd), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic mode, input logic [CW-1:0] cmd,
                               input logic [1:0] iv, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic cin);
    req_valid[r]               = 1'b1;
    req_mode[r]                = mode;
    req_cmd[r*CW +: CW]        = cmd;
    req_inp_valid[r*2 +: 2]    = iv;
    req_opa[r*DW +: DW]        = a;
    req_opb[r*DW +: DW]        = b;
    req_cin[r]                 = cin;
  endtask

  function automatic logic [63:0] all_outs();
    return {10'd0, req_ready, alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb,
            alu_cin, rsp_valid, rsp_id, rsp_res, rsp_flags};
  endfunction

  function automatic logic [63:0] alu_fields();
    return {alu_ce, alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] oh;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    RST = 1'b1;
    req_valid = '0; req_mode = '0; req_cmd = '0; req_inp_valid = '0;
    req_opa = '0; req_opb = '0; req_cin = '0;
    alu_res = 16'h0000; alu_flags = 6'h00; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Idle after reset with no requests: every output stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_outputs", all_outs(), 64'd0);
    end

    // Single ADD from requester 2.
    applyStimulus(2, 1'b1, 4'd0, 2'b11, 8'h0F, 8'h01, 1'b0);
    alu_res = 16'h1111; alu_flags = 6'h3F;
    #1;
    checkOutput("add_ready", {60'd0, req_ready}, 64'h4);
    tick();
    req_valid = '0;
    #1;
    checkOutput("add_issue_alu", alu_fields(), {1'b1, 2'b11, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0});
    checkOutput("add_issue_busy", {req_ready, rsp_valid}, 5'b0);
    tick();
    alu_res = 16'h0010; alu_flags = 6'h02;
    #1;
    checkOutput("add_wait_alu", alu_fields(), {1'b1, 2'b11, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0});
    tick();
    alu_res = 16'hDEAD; alu_flags = 6'h3F;
    #1;
    checkOutput("add_resp", {rsp_valid, rsp_id, rsp_res, rsp_flags, alu_ce, alu_inp_valid},
                {1'b1, 2'd2, 16'h0010, 6'h02, 1'b0, 2'b00});
    rsp_ready = 1'b1;
    tick();
    #1;
    checkOutput("add_resp_done", {63'd0, rsp_valid}, 64'd0);

    // Re-arm the pointer with a reset, then hold all four requesters valid.
    RST = 1'b1;
    req_valid = 4'b1111;
    alu_res = 16'h0055; alu_flags = 6'h01;
    #1;
    checkOutput("reset_ready_low", {60'd0, req_ready}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << exp_order[g];
      checkOutput("arb_grant", {60'd0, req_ready}, {60'd0, oh});
      tick();
      #1;
      checkOutput("arb_issue_ready", {60'd0, req_ready}, 64'd0);
      tick();
      tick();
      #1;
      checkOutput("arb_rsp_id", {rsp_valid, rsp_id, rsp_res}, {1'b1, 2'(exp_order[g]), 16'h0055});
      tick();
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Multiply from requester 1: two WAIT cycles.
    applyStimulus(1, 1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
    alu_res = 16'h1111; alu_flags = 6'h3F;
    #1;
    checkOutput("mul_ready", {60'd0, req_ready}, 64'h2);
    tick();
    req_valid = '0;
    #1;
    checkOutput("mul_issue_alu", alu_fields(), {1'b1, 2'b11, 1'b1, 4'd9, 8'h03, 8'h04, 1'b0});
    tick();
    alu_res = 16'hBAD1; alu_flags = 6'h2A;
    #1;
    checkOutput("mul_wait1", {alu_ce, rsp_valid}, 2'b10);
    tick();
    alu_res = 16'h000C; alu_flags = 6'h01;
    #1;
    checkOutput("mul_wait2", {alu_ce, rsp_valid}, 2'b10);
    tick();
    alu_res = 16'hDEAD; alu_flags = 6'h3F;
    applyStimulus(3, 1'b0, 4'd1, 2'b11, 8'hF0, 8'h0F, 1'b0);
    #1;
    checkOutput("mul_resp", {rsp_valid, rsp_id, rsp_res, rsp_flags}, {1'b1, 2'd1, 16'h000C, 6'h01});

    // Back-pressure: response and data hold, no grants while rsp_ready is low.
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_resp", {rsp_valid, rsp_id, rsp_res, rsp_flags, req_ready, alu_ce},
                  {1'b1, 2'd1, 16'h000C, 6'h01, 4'b0000, 1'b0});
      tick();
      #1;
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("hold_release", {rsp_valid, req_ready}, {1'b1, 4'b0000});
    tick();
    rsp_ready = 1'b0;
    #1;
    checkOutput("next_grant", {rsp_valid, req_ready}, {1'b0, 4'b1000});
    tick();
    req_valid = '0;
    alu_res = 16'h0042; alu_flags = 6'h04;
    tick();

    // Asynchronous reset while in WAIT.
    RST = 1'b1;
    req_valid = 4'b1111;
    #1;
    checkOutput("reset_in_wait", all_outs(), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("post_reset_grant", {rsp_valid, req_ready}, {1'b0, 4'b0001});
    tick();
    tick();
    rsp_ready = 1'b1;
    tick();
    #1;
    checkOutput("post_reset_rsp", {rsp_valid, rsp_id, rsp_res}, {1'b1, 2'd0, 16'h0042});
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    checkOutput("final_idle", {rsp_valid, alu_ce}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
